// File: rtl/AHBpkg.sv
// AHB-Lite SRAM slave shared definitions.
//
// Contents:
//   htrans_t, hsize_t, hburst_t, hresp_t  - bus field encodings
//   slv_state_t                           - slave response state machine
//   byte_en()  - byte-lane enables for a transfer size and low address bits
//   is_legal() - size/alignment/range legality of an address phase
package AHBpkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        HSIZE_BYTE  = 3'd0,
        HSIZE_HALF  = 3'd1,
        HSIZE_WORD  = 3'd2,
        HSIZE_DWORD = 3'd3,
        HSIZE_W4    = 3'd4,
        HSIZE_W8    = 3'd5,
        HSIZE_W16   = 3'd6,
        HSIZE_W32   = 3'd7
    } hsize_t;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_t;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01,
        HRESP_RETRY = 2'b10,
        HRESP_SPLIT = 2'b11
    } hresp_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ERR1 = 2'd2,
        S_ERR2 = 2'd3
    } slv_state_t;

    // Little-endian lane enables; sizes above a word enable nothing.
    function automatic logic [3:0] byte_en(hsize_t sz, logic [1:0] a);
        logic [3:0] be;
        case (sz)
            HSIZE_BYTE: be = 4'b0001 << a;
            HSIZE_HALF: be = a[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: be = 4'b1111;
            default:    be = 4'b0000;
        endcase
        return be;
    endfunction

    // Natural alignment for byte/half/word, and the byte address must fall
    // inside the 4*2**mem_aw byte window.
    function automatic logic is_legal(hsize_t sz, logic [31:0] addr, int mem_aw);
        logic ok;
        case (sz)
            HSIZE_BYTE: ok = 1'b1;
            HSIZE_HALF: ok = ~addr[0];
            HSIZE_WORD: ok = (addr[1:0] == 2'b00);
            default:    ok = 1'b0;
        endcase
        if ((addr >> (mem_aw + 2)) != 32'd0) ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/ahb_sram_mem.sv
// Byte-enabled 2**AW x 32 storage array.
//
// Ports:
//   clk    - write clock
//   we     - per-byte write enables (lane n = bits 8n+7:8n)
//   widx   - word index written
//   wdata  - write word
//   ridx   - word index read
//   rdata  - read word (asynchronous)
module ahb_sram_mem #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic [3:0]    we,
    input  logic [AW-1:0] widx,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] ridx,
    output logic [31:0]   rdata
);

    logic [31:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
        end
    end

    assign rdata = mem[ridx];

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite single-slave SRAM target with programmable wait states and a
// two-cycle ERROR response for illegal accesses.
//
// Optional build macro: AHB_SRAM_WPROT_EN - writes to word indices below
// WPROT_WORDS are answered with ERROR and leave memory untouched.
//
// Ports:
//   HCLK, HRESET          - clock, synchronous active-high reset
//   HSEL, HADDR, HTRANS,
//   HWRITE, HSIZE, HBURST - address phase
//   HWDATA                - write data (data phase)
//   HREADY, HRESP, HRDATA - response; HREADY is also the bus ready
//
// Handshake: an address phase is taken at a posedge where HREADY=1, HSEL=1
// and HTRANS is NONSEQ/SEQ; its data phase ends at the next posedge where
// HREADY=1, at which point a write commits and a read's HRDATA is valid.
module ahb_lite_sram_slave
    import AHBpkg::*;
#(
    parameter int MEM_AW      = 10,
    parameter int WAIT_STATES = 0,
    parameter int WPROT_WORDS = 16
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [31:0] HWDATA,
    output logic        HREADY,
    output logic [1:0]  HRESP,
    output logic [31:0] HRDATA
);

    slv_state_t        state, state_nxt;
    logic [3:0]        wcnt_q;
    logic              dphase_q;    // a legal data phase is outstanding
    logic              write_q;
    hsize_t            size_q;
    logic [MEM_AW+1:0] addr_q;
    logic              accept;
    logic              acc_legal;
    logic [3:0]        we;
    logic [31:0]       rdata;
    htrans_t           trans;
    hburst_t           unused_burst;

    assign trans        = htrans_t'(HTRANS);
    assign unused_burst = hburst_t'(HBURST);
    assign accept       = HREADY && HSEL &&
                          (trans == HTRANS_NONSEQ || trans == HTRANS_SEQ);

`ifdef AHB_SRAM_WPROT_EN
    assign acc_legal = is_legal(hsize_t'(HSIZE), HADDR, MEM_AW) &&
                       !(HWRITE && (HADDR[31:2] < 30'(WPROT_WORDS)));
`else
    logic unused_wprot;
    assign unused_wprot = (WPROT_WORDS != 0);
    assign acc_legal    = is_legal(hsize_t'(HSIZE), HADDR, MEM_AW);
`endif

    // State register
    always_ff @(posedge HCLK) begin
        if (HRESET) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next state; ERR2 drives HREADY high so it takes a new address phase
    // exactly like IDLE does.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_ERR2: begin
                if (!accept)               state_nxt = S_IDLE;
                else if (!acc_legal)       state_nxt = S_ERR1;
                else if (WAIT_STATES > 0)  state_nxt = S_WAIT;
                else                       state_nxt = S_IDLE;
            end
            S_WAIT:  if (wcnt_q == 4'd1) state_nxt = S_IDLE;
            S_ERR1:  state_nxt = S_ERR2;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        HREADY = 1'b1;
        HRESP  = HRESP_OKAY;
        case (state)
            S_WAIT:  HREADY = 1'b0;
            S_ERR1:  begin HREADY = 1'b0; HRESP = HRESP_ERROR; end
            S_ERR2:  HRESP = HRESP_ERROR;
            default: ;
        endcase
        HRDATA = (dphase_q && !write_q) ? rdata : 32'h0;
        // Commit on the edge that ends the data phase; a reset on that edge
        // cancels it.
        we = (state == S_IDLE && dphase_q && write_q && !HRESET) ?
             byte_en(size_q, addr_q[1:0]) : 4'b0000;
    end

    // Address-phase capture and wait counter
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            wcnt_q   <= 4'd0;
            dphase_q <= 1'b0;
            write_q  <= 1'b0;
            size_q   <= HSIZE_BYTE;
            addr_q   <= '0;
        end else begin
            if (accept) begin
                addr_q  <= HADDR[MEM_AW+1:0];
                write_q <= HWRITE;
                size_q  <= hsize_t'(HSIZE);
            end
            if (HREADY) dphase_q <= accept && acc_legal;
            if (accept && acc_legal)  wcnt_q <= 4'(WAIT_STATES);
            else if (state == S_WAIT) wcnt_q <= wcnt_q - 4'd1;
        end
    end

    ahb_sram_mem #(.AW(MEM_AW)) u_mem (
        .clk   (HCLK),
        .we    (we),
        .widx  (addr_q[MEM_AW+1:2]),
        .wdata (HWDATA),
        .ridx  (addr_q[MEM_AW+1:2]),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Bench for ahb_lite_sram_slave: two instances (0 and 3 wait states) share
// the address/data buses; only the selected one sees HSEL. A byte-addressed
// reference memory predicts read data, response and wait-cycle counts.
module tb_ahb_lite_sram_slave;

  localparam int MEM_AW      = 10;
  localparam int WPROT_WORDS = 16;
  localparam int MEM_BYTES   = 4 << MEM_AW;

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        w;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [31:0] addr;
    logic [31:0] wdata;
  } xfer_t;

  logic        hclk;
  logic        hreset;
  logic        hsel_act;
  logic        hsel0, hsel3;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic        hready0, hready3, hready_m;
  logic [1:0]  hresp0, hresp3, hresp_m;
  logic [31:0] hrdata0, hrdata3, hrdata_m;
  int          dut_sel;

  int n_checks;
  int n_errors;

  xfer_t       xq[$];
  logic [31:0] exp_q[$];
  bit          chk_q[$];

  logic [7:0] ref_mem [2][MEM_BYTES];
  bit         ref_vld [2][MEM_BYTES];

  assign hsel0    = hsel_act && (dut_sel == 0);
  assign hsel3    = hsel_act && (dut_sel != 0);
  assign hready_m = (dut_sel != 0) ? hready3 : hready0;
  assign hresp_m  = (dut_sel != 0) ? hresp3  : hresp0;
  assign hrdata_m = (dut_sel != 0) ? hrdata3 : hrdata0;

  ahb_lite_sram_slave #(.MEM_AW(MEM_AW), .WAIT_STATES(0), .WPROT_WORDS(WPROT_WORDS)) u_ws0 (
    .HCLK(hclk), .HRESET(hreset), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata),
    .HREADY(hready0), .HRESP(hresp0), .HRDATA(hrdata0)
  );

  ahb_lite_sram_slave #(.MEM_AW(MEM_AW), .WAIT_STATES(3), .WPROT_WORDS(WPROT_WORDS)) u_ws3 (
    .HCLK(hclk), .HRESET(hreset), .HSEL(hsel3), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata),
    .HREADY(hready3), .HRESP(hresp3), .HRDATA(hrdata3)
  );

  // clock / watchdog
  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  initial begin
    #400000;
    $display("FAIL watchdog: run exceeded time limit (got timeout, expected completion)");
    $fatal(1, "watchdog");
  end

  // checking
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference model
  function automatic int cur_ws();
    return (dut_sel != 0) ? 3 : 0;
  endfunction

  function automatic bit model_legal(input xfer_t t);
    int nb;
    if (t.size > 3'd2) return 1'b0;
    nb = 1 << t.size;
    if ((t.addr & 32'(nb - 1)) != 32'd0) return 1'b0;
    if (t.addr >= 32'(MEM_BYTES)) return 1'b0;
`ifdef AHB_SRAM_WPROT_EN
    if (t.w && t.addr < 32'(4 * WPROT_WORDS)) return 1'b0;
`endif
    return 1'b1;
  endfunction

  function automatic void model_write(input xfer_t t);
    int a, nb, lane;
    a  = int'(t.addr[11:0]);
    nb = 1 << t.size;
    for (int k = 0; k < nb; k++) begin
      lane = (a + k) % 4;
      ref_mem[dut_sel][a + k] = t.wdata[8*lane +: 8];
      ref_vld[dut_sel][a + k] = 1'b1;
    end
  endfunction

  function automatic void model_read(input logic [31:0] addr, output logic [31:0] data, output bit ok);
    int b;
    b    = int'(addr[11:2]) * 4;
    ok   = 1'b1;
    data = 32'h0;
    for (int k = 0; k < 4; k++) begin
      data[8*k +: 8] = ref_mem[dut_sel][b + k];
      if (!ref_vld[dut_sel][b + k]) ok = 1'b0;
    end
  endfunction

  // driver tasks
  task automatic push_x(input logic sel, input logic [1:0] trans, input logic w,
                        input logic [2:0] size, input logic [2:0] burst,
                        input logic [31:0] addr, input logic [31:0] wdata);
    xfer_t t;
    t.sel = sel; t.trans = trans; t.w = w; t.size = size;
    t.burst = burst; t.addr = addr; t.wdata = wdata;
    xq.push_back(t);
  endtask

  task automatic push_wr(input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wdata);
    push_x(1'b1, 2'b10, 1'b1, size, 3'd0, addr, wdata);
  endtask

  task automatic push_rd(input logic [2:0] size, input logic [31:0] addr);
    push_x(1'b1, 2'b10, 1'b0, size, 3'd0, addr, 32'h0);
  endtask

  task automatic rand_fill(input int n, input int wlo, input int whi);
    xfer_t t;
    int r;
    for (int i = 0; i < n; i++) begin
      r = int'($urandom_range(0, 19));
      t.trans = (r < 2) ? 2'b00 : (r < 4) ? 2'b01 : (r < 12) ? 2'b10 : 2'b11;
      t.sel   = ($urandom_range(0, 9) != 0);
      t.w     = 1'($urandom_range(0, 1));
      t.size  = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      t.burst = 3'($urandom_range(0, 7));
      t.addr  = 32'($urandom_range(wlo, whi)) << 2;
      if ($urandom_range(0, 4) == 0)  t.addr = t.addr + 32'($urandom_range(0, 3));
      else if (t.size == 3'd0)        t.addr = t.addr + 32'($urandom_range(0, 3));
      else if (t.size == 3'd1)        t.addr = t.addr + 32'($urandom_range(0, 1) * 2);
      if ($urandom_range(0, 24) == 0) t.addr = 32'h1000 + (32'($urandom_range(0, 1023)) << 2);
      t.wdata = $urandom;
      xq.push_back(t);
    end
  endtask

  // Runs xq back-to-back as a pipelined master; called and returns at
  // posedge+1. data_cycles counts clock cycles spent in data phases.
  task automatic run_seq(output int data_cycles);
    xfer_t       dp;
    bit          dp_v, dp_legal, c;
    int          idx, lo, n;
    logic        r;
    logic [1:0]  p;
    logic [31:0] d, e;
    dp_v = 1'b0; dp_legal = 1'b0; idx = 0; lo = 0; data_cycles = 0;
    n = xq.size();
    while (idx < n || dp_v) begin
      if (idx < n) begin
        hsel_act = xq[idx].sel; htrans = xq[idx].trans; hwrite = xq[idx].w;
        hsize = xq[idx].size; hburst = xq[idx].burst; haddr = xq[idx].addr;
      end else begin
        hsel_act = 1'b1; htrans = 2'b00;
      end
      hwdata = dp_v ? dp.wdata : 32'h0;
      @(negedge hclk);
      r = hready_m; p = hresp_m; d = hrdata_m;
      if (dp_v) begin
        data_cycles++;
        if (!r) begin
          lo++;
          check_eq("lowphase_resp", 32'(p), dp_legal ? 32'd0 : 32'd1);
          if (lo > 20) begin
            check_eq("hready_timeout", 32'(lo), dp_legal ? 32'(cur_ws()) : 32'd1);
            dp_v = 1'b0;
            idx  = n;
          end
        end else begin
          check_eq("wait_cycles", 32'(lo), dp_legal ? 32'(cur_ws()) : 32'd1);
          check_eq("final_resp", 32'(p), dp_legal ? 32'd0 : 32'd1);
          e = exp_q.pop_front();
          c = chk_q.pop_front();
          if (c) begin
            if (dp.w || !dp_legal) check_eq("rdata_zero", d, e);
            else                   check_eq("rd_data", d, e);
          end
          if (dp_legal && dp.w) model_write(dp);
          lo = 0;
        end
      end else begin
        check_eq("idle_hready", 32'(r), 32'd1);
        check_eq("idle_hresp", 32'(p), 32'd0);
        check_eq("idle_rdata", d, 32'h0);
      end
      @(posedge hclk); #1;
      if (r) begin
        dp_v = 1'b0;
        if (idx < n) begin
          if (xq[idx].sel && xq[idx].trans[1]) begin
            dp       = xq[idx];
            dp_v     = 1'b1;
            dp_legal = model_legal(dp);
            if (!dp_legal || dp.w) begin
              exp_q.push_back(32'h0); chk_q.push_back(1'b1);
            end else begin
              model_read(dp.addr, e, c);
              exp_q.push_back(e); chk_q.push_back(c);
            end
          end
          idx++;
        end
      end
    end
    htrans = 2'b00;
    hsel_act = 1'b1;
    xq.delete(); exp_q.delete(); chk_q.delete();
  endtask

  // main sequence
  initial begin
    int dc;
    n_checks = 0; n_errors = 0;
    hreset = 1'b1; hsel_act = 1'b1; dut_sel = 0;
    haddr = 32'h0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd0; hburst = 3'd0; hwdata = 32'h0;
    repeat (3) @(posedge hclk);
    #1 hreset = 1'b0;
    @(negedge hclk);
    check_eq("rst_hready_ws0", 32'(hready0), 32'd1);
    check_eq("rst_hresp_ws0",  32'(hresp0),  32'd0);
    check_eq("rst_hrdata_ws0", hrdata0,      32'h0);
    check_eq("rst_hready_ws3", 32'(hready3), 32'd1);
    check_eq("rst_hresp_ws3",  32'(hresp3),  32'd0);
    check_eq("rst_hrdata_ws3", hrdata3,      32'h0);
    @(posedge hclk); #1;

    // zero-wait instance
    dut_sel = 0;
    for (int w = 0; w < 64; w++) push_wr(3'd2, 32'(w * 4), $urandom);
    run_seq(dc);

    for (int b = 0; b < 2; b++) begin
      logic [31:0] base;
      base = (b == 0) ? 32'h10 : 32'h50;
      push_wr(3'd2, base, 32'hDEADBEEF);
      push_rd(3'd2, base);
      push_wr(3'd2, base, 32'h11223344);
      push_wr(3'd0, base + 32'd3, 32'hAA000000);
      push_rd(3'd2, base);
      push_wr(3'd1, base + 32'd2, 32'h55660000);
      push_rd(3'd2, base);
    end
    run_seq(dc);

    push_wr(3'd2, 32'h02, 32'hBAD0BAD0);
    push_rd(3'd2, 32'h00);
    push_wr(3'd3, 32'h10, 32'hBAD1BAD1);
    push_rd(3'd2, 32'h10);
    push_wr(3'd2, 32'h1000, 32'hBAD2BAD2);
    push_rd(3'd2, 32'h00);
    push_rd(3'd1, 32'h51);
    push_rd(3'd2, 32'h50);
    run_seq(dc);

    push_wr(3'd2, 32'h3C, 32'hCAFEF00D);
    push_rd(3'd2, 32'h3C);
    push_wr(3'd2, 32'h40, 32'h0BADCAFE);
    push_rd(3'd2, 32'h40);
    run_seq(dc);

    rand_fill(80, 0, 63);
    run_seq(dc);

    // three-wait instance
    dut_sel = 1;
    for (int w = 32; w < 40; w++) push_wr(3'd2, 32'(w * 4), $urandom);
    run_seq(dc);

    push_rd(3'd2, 32'h84);
    run_seq(dc);
    check_eq("single_read_cycles", 32'(dc), 32'd4);

    push_x(1'b1, 2'b10, 1'b0, 3'd2, 3'd3, 32'h80, 32'h0);
    push_x(1'b1, 2'b11, 1'b0, 3'd2, 3'd3, 32'h84, 32'h0);
    push_x(1'b1, 2'b11, 1'b0, 3'd2, 3'd3, 32'h88, 32'h0);
    push_x(1'b1, 2'b11, 1'b0, 3'd2, 3'd3, 32'h8C, 32'h0);
    run_seq(dc);
    check_eq("incr4_data_cycles", 32'(dc), 32'd16);

    // reset while a write waits: the write must be dropped
    hsel_act = 1'b1; haddr = 32'h88; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2; hburst = 3'd0;
    @(posedge hclk); #1;
    htrans = 2'b00; hwdata = 32'h0F0F0F0F;
    @(negedge hclk);
    check_eq("rstw_hready_low", 32'(hready_m), 32'd0);
    @(posedge hclk); #1;
    hreset = 1'b1;
    @(posedge hclk); #1;
    hreset = 1'b0;
    @(negedge hclk);
    check_eq("rstw_hready", 32'(hready_m), 32'd1);
    check_eq("rstw_hresp",  32'(hresp_m),  32'd0);
    check_eq("rstw_hrdata", hrdata_m,      32'h0);
    @(posedge hclk); #1;
    hwdata = 32'h0;
    push_rd(3'd2, 32'h88);
    run_seq(dc);

    rand_fill(30, 30, 41);
    run_seq(dc);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ahb_lite_sram_slave.md
Name: ahb_lite_sram_slave

Overview:
AHB-Lite slave sitting directly downstream of the bus interface. It consumes HADDR/HTRANS/HSIZE/HBURST/HWRITE/HWDATA and produces HREADY/HRESP/HRDATA. It is the single-slave memory target that the driver and monitor exercise.
- Word-addressed SRAM with byte lanes.
- Programmable wait states.
- Two-cycle ERROR response for illegal accesses.

Parameters:
- MEM_AW, 10: word-index bits; memory = 2**MEM_AW 32-bit words; byte range 0 .. 4*2**MEM_AW-1.
- WAIT_STATES, 0: HREADY-low cycles inserted in every OKAY NONSEQ/SEQ data phase; range 0..15.
- WPROT_WORDS, 16: size in words of the write-protected low region. Used only with the optional feature.

Ports:
- HCLK  in  1  bus clock; all logic on posedge.
- HRESET  in  1  synchronous, active-high reset.
- HSEL  in  1  slave select; tie 1 in single-slave bench.
- HADDR  in  32  byte address (address phase).
- HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- HWRITE  in  1  1=write.
- HSIZE  in  3  0=byte, 1=half, 2=word; >2 illegal.
- HBURST  in  3  burst type; accepted, not checked.
- HWDATA  in  32  write data (data phase).
- HREADY  out  1  transfer done / slave ready. Also serves as the bus HREADY, since this is the only slave.
- HRESP  out  2  OKAY=00, ERROR=01; RETRY/SPLIT never driven.
- HRDATA  out  32  read data, valid when HREADY=1 and HRESP=OKAY.

Behaviour:
Reset (HRESET=1 at posedge):
- state=IDLE, HREADY=1, HRESP=OKAY, HRDATA=0.
- Any pending data phase is discarded; no memory write occurs.
- Memory contents are retained (not cleared).
- Applies mid-wait and mid-error.

Address phase:
- Sampled at a posedge with HREADY=1, HSEL=1 and HTRANS[1]=1 (NONSEQ/SEQ).
- Registers addr_q, write_q, size_q.
- IDLE/BUSY, or HSEL=0: no data phase; next cycle is OKAY with zero wait.

Legality check (address phase):
- Illegal if any of the following hold: HSIZE>2; HSIZE=1 and HADDR[0]=1; HSIZE=2 and HADDR[1:0]!=0; HADDR >= 4*2**MEM_AW.

State machine: IDLE, WAIT, ERR1, ERR2.
- IDLE: HREADY=1.
  - Legal access, WAIT_STATES>0 -> WAIT, count=WAIT_STATES.
  - Legal access, WAIT_STATES=0 -> data phase completes next cycle; stay IDLE.
  - Illegal access -> ERR1.
- WAIT: HREADY=0, HRESP=OKAY. Decrement count; at count=1 -> IDLE, where the data phase completes with HREADY=1.
- ERR1: HREADY=0, HRESP=ERROR -> ERR2.
- ERR2: HREADY=1, HRESP=ERROR -> IDLE. An address phase presented during ERR2 is accepted normally.

Write commit:
- mem[addr_q[MEM_AW+1:2]] byte lanes are updated at the posedge ending the data phase (HREADY=1, OKAY).
- Byte enables by size_q/addr_q[1:0]:
  - byte: lane = addr[1:0].
  - half: lanes {1,0} or {3,2}.
  - word: all lanes.
- Little-endian; HWDATA lane n = bits 8n+7:8n.

Reads:
- HRDATA = full word mem[addr_q index] during the data phase. Unselected lanes are also driven from memory.
- HRDATA is 0 outside read data phases and on ERROR.
- Write to address A immediately followed by a read of A returns the new data, because the commit precedes the read data phase.

Error responses:
- ERROR never modifies memory.
- The master's following transfer is accepted regardless.

Optional Feature:
AHB_SRAM_WPROT_EN
- Defined: a legal write with word index < WPROT_WORDS is treated as illegal. It takes the ERR1/ERR2 path and memory is unchanged. Reads of the region remain OKAY.
- Undefined: WPROT_WORDS is ignored; all in-range aligned writes are OKAY.

Decomposition:
Package AHBpkg:
- htrans_t, hsize_t, hburst_t, hresp_t enums with the encodings above.
- slave state enum {IDLE, WAIT, ERR1, ERR2}.
- Function byte_en(hsize_t, logic[1:0]) returning logic[3:0].
- Function is_legal(hsize_t, addr, mem_aw).

Sub-module ahb_sram_mem:
- Byte-enabled 2**MEM_AW x 32 array.
- Ports: clk, we[3:0], widx, wdata, ridx, rdata (asynchronous read).

Test Plan:
- Reset -> HREADY=1, HRESP=00, HRDATA=0. Reset asserted during WAIT -> next cycle HREADY=1 and the pending write is not committed.
- WAIT_STATES=0: word write 0xDEADBEEF at 0x10, then read 0x10 back-to-back -> HRDATA=0xDEADBEEF, HREADY never low.
- Byte write 0xAA at 0x13 over word 0x11223344 -> read 0x10 returns 0xAA223344. Halfword 0x5566 at 0x12 -> 0x55663344.
- WAIT_STATES=3: NONSEQ read -> exactly 3 cycles HREADY=0 then data. A 4-beat INCR4 SEQ burst takes 16 data cycles.
- Illegal accesses, each -> HREADY 0 then 1 with HRESP=01 on both cycles, and memory unchanged on readback:
  - word at 0x02;
  - HSIZE=3;
  - address 0x1000 with MEM_AW=10.
- With AHB_SRAM_WPROT_EN, WPROT_WORDS=16: write 0x3C -> ERROR, readback unchanged; write 0x40 -> OKAY. Without the macro, write 0x3C -> OKAY.
